// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NUM_REQ byte sources.
// The transmitter has no busy or done output, so this block counts the frame and
// guard time itself and holds tx_byte steady for the whole transfer.
// Ports:
//   clock, reset_n   system clock (rising edge), asynchronous active-low reset
//   req              per-requester pending flag (level, held until granted)
//   req_data         byte of requester i at [8*i+7:8*i]
//   grant            one-hot, 1-cycle pulse when a requester's byte is accepted
//   grant_id         index of the last granted requester
//   tx_byte          byte to the transmitter, stable from START through the end of WAIT
//   start_transfert  1-cycle start pulse to the transmitter
//   busy             high whenever the arbiter is not idle
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned FRAME_CYCLES = 10,
  parameter int unsigned GUARD_CYCLES = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [7:0]                 tx_byte,
  output logic                       start_transfert,
  output logic                       busy
);

  localparam int unsigned IW         = $clog2(NUM_REQ);
  localparam int unsigned CMAX       = (FRAME_CYCLES > GUARD_CYCLES) ? FRAME_CYCLES : GUARD_CYCLES;
  localparam int unsigned CW         = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int unsigned FRAME_LOAD = FRAME_CYCLES - 1;
  localparam int unsigned GUARD_LOAD = (GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        counter, counter_nxt;
  logic [IW-1:0]        rr_ptr, rr_ptr_nxt;

  logic [NUM_REQ-1:0]   grant_nxt;
  logic [IW-1:0]        grant_id_nxt;
  logic [7:0]           tx_byte_nxt;
  logic                 start_nxt;
  logic                 busy_nxt;

  logic                 win_valid;
  logic [IW-1:0]        win;
  logic [7:0]           win_data;
  logic [IW:0]          cand;

  // Round-robin scan: first pending requester at or after rr_ptr, wrapping.
  always_comb begin
    win_valid = 1'b0;
    win       = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(i);
      if (cand >= (IW+1)'(NUM_REQ)) cand = cand - (IW+1)'(NUM_REQ);
      if (!win_valid && req[cand[IW-1:0]]) begin
        win_valid = 1'b1;
        win       = cand[IW-1:0];
      end
    end
  end

  // Only the winner's byte is picked out of req_data.
  always_comb begin
    win_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win == IW'(j)) win_data = req_data[8*j +: 8];
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= ST_IDLE;
      counter         <= '0;
      rr_ptr          <= '0;
      grant           <= '0;
      grant_id        <= '0;
      tx_byte         <= '0;
      start_transfert <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_nxt;
      counter         <= counter_nxt;
      rr_ptr          <= rr_ptr_nxt;
      grant           <= grant_nxt;
      grant_id        <= grant_id_nxt;
      tx_byte         <= tx_byte_nxt;
      start_transfert <= start_nxt;
      busy            <= busy_nxt;
    end
  end

  // Next state and frame/guard countdown.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    case (state)
      ST_IDLE: begin
        if (win_valid) state_nxt = ST_START;
      end
      ST_START: begin
        counter_nxt = CW'(FRAME_LOAD);
        state_nxt   = ST_WAIT;
      end
      ST_WAIT: begin
        if (counter == '0) begin
          if (GUARD_CYCLES > 0) begin
            counter_nxt = CW'(GUARD_LOAD);
            state_nxt   = ST_GUARD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          counter_nxt = counter - CW'(1);
        end
      end
      ST_GUARD: begin
        if (counter == '0) state_nxt = ST_IDLE;
        else               counter_nxt = counter - CW'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; tx_byte and grant_id hold outside a grant.
  always_comb begin
    grant_nxt    = '0;
    start_nxt    = 1'b0;
    tx_byte_nxt  = tx_byte;
    grant_id_nxt = grant_id;
    rr_ptr_nxt   = rr_ptr;
    busy_nxt     = (state_nxt != ST_IDLE);
    if (state == ST_IDLE && win_valid) begin
      grant_nxt    = NUM_REQ'(1) << win;
      start_nxt    = 1'b1;
      tx_byte_nxt  = win_data;
      grant_id_nxt = win;
      rr_ptr_nxt   = (win == IW'(NUM_REQ - 1)) ? '0 : win + IW'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with default parameters (4 requesters,
// 10-cycle frame, 1-cycle guard => 13-cycle start-to-start period).
module tb_uart_tx_arbiter;

  logic        clock;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  grant;
  logic [1:0]  grant_id;
  logic [7:0]  tx_byte;
  logic        start_transfert;
  logic        busy;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .req             (req),
    .req_data        (req_data),
    .grant           (grant),
    .grant_id        (grant_id),
    .tx_byte         (tx_byte),
    .start_transfert (start_transfert),
    .busy            (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Waits for the next start pulse (sampled on negedges); reports the grant index,
  // cycles elapsed, and whether busy was already high in the cycle before.
  task automatic wait_start(output int id, output int cyc, output logic prev_busy);
    logic pb;
    id = -1; cyc = 0; prev_busy = 1'b0;
    for (int n = 0; n < 60; n++) begin
      pb = busy;
      @(negedge clock);
      cyc++;
      if (start_transfert) begin
        id = int'(grant_id);
        prev_busy = pb;
        return;
      end
    end
    check_eq("start_timeout", start_transfert, 1);
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 40; n++) begin
      if (!busy) return;
      @(negedge clock);
    end
    check_eq("idle_timeout", busy, 0);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int id, cyc, nb;
    logic pb;
    logic [7:0] rx;
    logic [7:0] exp_b [4];

    reset_n  = 1'b0;
    req      = '0;
    req_data = '0;

    // Reset values, before any clock edge
    #3;
    check_eq("rst_grant", grant, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_tx_byte", tx_byte, 0);
    check_eq("rst_start", start_transfert, 0);
    check_eq("rst_busy", busy, 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Single request: 1-cycle latency, busy for 12 cycles
    req_data[7:0] = 8'hE6;
    req = 4'b0001;
    @(negedge clock);
    check_eq("t2_grant", grant, 4'b0001);
    check_eq("t2_start", start_transfert, 1);
    check_eq("t2_tx_byte", tx_byte, 8'hE6);
    check_eq("t2_grant_id", grant_id, 0);
    check_eq("t2_busy", busy, 1);
    req = 4'b0000;
    nb = 1;
    for (int n = 0; n < 30; n++) begin
      @(negedge clock);
      if (n == 5) begin
        check_eq("t2_wait_grant", grant, 0);
        check_eq("t2_wait_start", start_transfert, 0);
        check_eq("t2_wait_hold", tx_byte, 8'hE6);
      end
      if (busy) nb++;
      else break;
    end
    check_eq("t2_busy_cycles", nb, 12);

    // All requesting: 0,1,2,3,0 at 13-cycle spacing
    pulse_reset();
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_start(id, cyc, pb);
      check_eq($sformatf("t3_id%0d", n), id, n % 4);
      check_eq($sformatf("t3_grant%0d", n), grant, 32'(1) << (n % 4));
      check_eq($sformatf("t3_period%0d", n), cyc, (n == 0) ? 1 : 13);
    end
    req = 4'b0000;
    wait_idle();

    // Grant 1, then 1010 raised in the grant cycle: 3 wins before 1
    req = 4'b0010;
    wait_start(id, cyc, pb);
    check_eq("t4_first", id, 1);
    req = 4'b1010;
    wait_start(id, cyc, pb);
    check_eq("t4_second", id, 3);
    check_eq("t4_second_gap", cyc, 13);
    req = 4'b0010;
    wait_start(id, cyc, pb);
    check_eq("t4_third", id, 1);
    check_eq("t4_third_gap", cyc, 13);
    req = 4'b0000;
    wait_idle();

    // Reset during WAIT clears immediately and restarts round-robin at 0
    req = 4'b0100;
    wait_start(id, cyc, pb);
    check_eq("t5_pre_id", id, 2);
    req = 4'b0000;
    repeat (3) @(negedge clock);
    check_eq("t5_pre_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check_eq("t5_busy", busy, 0);
    check_eq("t5_grant_id", grant_id, 0);
    check_eq("t5_tx_byte", tx_byte, 0);
    check_eq("t5_start", start_transfert, 0);
    @(negedge clock);
    reset_n = 1'b1;
    req = 4'b1111;
    wait_start(id, cyc, pb);
    check_eq("t5_after_id", id, 0);
    check_eq("t5_after_lat", cyc, 1);
    req = 4'b0000;
    wait_idle();

    // Loopback: bits read back from tx_byte across the frame, in grant order
    pulse_reset();
    exp_b[0] = 8'hE6; exp_b[1] = 8'h00; exp_b[2] = 8'hFF; exp_b[3] = 8'h5A;
    req_data = 32'h5AFF00E6;
    req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      wait_start(id, cyc, pb);
      check_eq($sformatf("t6_id%0d", n), id, n);
      check_eq($sformatf("t6_idle_before%0d", n), pb, 0);
      req = req & ~grant;
      rx = '0;
      for (int k = 0; k < 8; k++) begin
        @(negedge clock);
        rx[k] = tx_byte[k];
      end
      check_eq($sformatf("t6_rx%0d", n), rx, exp_b[n]);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
